// File: rtl/node_id_recycler_if.sv
// Freed-ID / allocation handshake bundle for node_id_recycler.
// The slave modport is the recycler; the master modport is the mutation engine.
interface node_id_recycler_if #(
  parameter int unsigned MAX_RECYCLE = 8,
  parameter int unsigned DATA_WIDTH  = 8
);
  logic                           free_valid;
  logic [DATA_WIDTH-1:0]          free_id;
  logic                           free_ready;
  logic                           alloc_req;
  logic                           alloc_valid;
  logic [DATA_WIDTH-1:0]          alloc_id;
  logic                           alloc_recycled;
  logic                           alloc_err;
  logic [$clog2(MAX_RECYCLE):0]   count;
  logic                           empty;
  logic                           full;
  logic                           dup_drop;

  modport master (
    output free_valid, free_id, alloc_req,
    input  free_ready, alloc_valid, alloc_id, alloc_recycled, alloc_err,
           count, empty, full, dup_drop
  );

  modport slave (
    input  free_valid, free_id, alloc_req,
    output free_ready, alloc_valid, alloc_id, alloc_recycled, alloc_err,
           count, empty, full, dup_drop
  );
endinterface

// File: rtl/node_id_recycler.sv
// Recycles freed node IDs oldest-first, falling back to a saturating fresh-ID counter.
// Optional macro RECYCLE_DUP_CHECK_EN drops freed IDs already held in the FIFO.
module node_id_recycler #(
  parameter int unsigned MAX_RECYCLE    = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_INIT_NODES = 8
) (
  input  logic              clk,
  input  logic              rst,
  node_id_recycler_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(MAX_RECYCLE);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] INVALID_ID = '1;

  logic [DATA_WIDTH-1:0] mem [MAX_RECYCLE];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] fresh;
  logic [DATA_WIDTH-1:0] alloc_id_q;
  logic                  alloc_valid_q;
  logic                  alloc_recycled_q;
  logic                  alloc_err_q;

  logic empty_w;
  logic full_w;
  logic push_try;
  logic push;
  logic pop;
  logic dup_hit;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CNT_W'(MAX_RECYCLE));
  assign push_try = bus.free_valid && !full_w && (bus.free_id != INVALID_ID);
  assign push     = push_try && !dup_hit;
  assign pop      = bus.alloc_req && !empty_w;

`ifdef RECYCLE_DUP_CHECK_EN
  logic [PTR_W-1:0] slot_off [MAX_RECYCLE];
  logic             dup_drop_q;

  // A slot is live when its distance from head (mod depth) is below the occupancy.
  always_comb begin
    dup_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_RECYCLE; i++) begin
      slot_off[i] = PTR_W'(i) - head;
      if ((CNT_W'(slot_off[i]) < count_q) && (mem[i] == bus.free_id)) begin
        dup_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dup_drop_q <= 1'b0;
    end else begin
      dup_drop_q <= push_try && dup_hit;
    end
  end

  assign bus.dup_drop = dup_drop_q;
`else
  assign dup_hit      = 1'b0;
  assign bus.dup_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= bus.free_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head             <= '0;
      tail             <= '0;
      count_q          <= '0;
      fresh            <= DATA_WIDTH'(NUM_INIT_NODES);
      alloc_id_q       <= '1;
      alloc_valid_q    <= 1'b0;
      alloc_recycled_q <= 1'b0;
      alloc_err_q      <= 1'b0;
    end else begin
      alloc_valid_q    <= bus.alloc_req;
      alloc_recycled_q <= 1'b0;
      alloc_err_q      <= 1'b0;
      if (bus.alloc_req) begin
        if (!empty_w) begin
          alloc_id_q       <= mem[head];
          alloc_recycled_q <= 1'b1;
          head             <= head + 1'b1;
        end else if (fresh != INVALID_ID) begin
          alloc_id_q <= fresh;
          fresh      <= fresh + 1'b1;
        end else begin
          alloc_id_q  <= INVALID_ID;
          alloc_err_q <= 1'b1;
        end
      end
      if (push) begin
        tail <= tail + 1'b1;
      end
      // Push into an empty FIFO is not bypassed to a same-cycle pop (pop comes from fresh).
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.free_ready     = !full_w;
  assign bus.alloc_valid    = alloc_valid_q;
  assign bus.alloc_id       = alloc_id_q;
  assign bus.alloc_recycled = alloc_recycled_q;
  assign bus.alloc_err      = alloc_err_q;
  assign bus.count          = count_q;
  assign bus.empty          = empty_w;
  assign bus.full           = full_w;
endmodule

// File: tb/tb_node_id_recycler.sv
// Self-checking bench for node_id_recycler: directed scenarios plus random traffic
// against a queue-based reference model (honours RECYCLE_DUP_CHECK_EN).
module tb_node_id_recycler;
  localparam int unsigned MAXR = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned NIN  = 8;
  localparam int          INV  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  node_id_recycler_if #(.MAX_RECYCLE(MAXR), .DATA_WIDTH(DW)) bus ();

  node_id_recycler #(
    .MAX_RECYCLE   (MAXR),
    .DATA_WIDTH    (DW),
    .NUM_INIT_NODES(NIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int q[$];
  int m_fresh;
  int m_id;
  bit m_valid, m_rec, m_err, m_dup;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fresh = NIN;
    m_id    = INV;
    m_valid = 0; m_rec = 0; m_err = 0; m_dup = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},    32'(bus.alloc_valid),    32'(m_valid));
    check({tag, ".id"},       32'(bus.alloc_id),       32'(m_id));
    check({tag, ".recycled"}, 32'(bus.alloc_recycled), 32'(m_rec));
    check({tag, ".err"},      32'(bus.alloc_err),      32'(m_err));
    check({tag, ".count"},    32'(bus.count),          32'(q.size()));
    check({tag, ".empty"},    32'(bus.empty),          32'(q.size() == 0));
    check({tag, ".full"},     32'(bus.full),           32'(q.size() == MAXR));
    check({tag, ".ready"},    32'(bus.free_ready),     32'(q.size() < MAXR));
    check({tag, ".dup"},      32'(bus.dup_drop),       32'(m_dup));
  endtask

  // One clock: predict from the model, drive, clock, compare.
  task automatic step(input string tag, input bit fv, input int fid, input bit req);
    int  pre;
    bit  full_now, dup, push;
    pre      = q.size();
    full_now = (pre == MAXR);
    dup      = 0;
`ifdef RECYCLE_DUP_CHECK_EN
    foreach (q[k]) if (q[k] == fid) dup = 1;
`endif
    push  = fv && !full_now && fid != INV && !dup;
    m_dup = fv && !full_now && fid != INV && dup;
    m_valid = req; m_rec = 0; m_err = 0;
    if (req) begin
      if (pre > 0) begin
        m_id = q.pop_front(); m_rec = 1;
      end else if (m_fresh != INV) begin
        m_id = m_fresh; m_fresh++;
      end else begin
        m_id = INV; m_err = 1;
      end
    end
    if (push) q.push_back(fid);
    bus.free_valid = fv;
    bus.free_id    = DW'(fid);
    bus.alloc_req  = req;
    @(posedge clk); #1;
    bus.free_valid = 1'b0;
    bus.alloc_req  = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    bus.free_valid = 1'b0;
    bus.free_id    = '0;
    bus.alloc_req  = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    #2 check_all("por");
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: fresh IDs 8,9,10
    for (int i = 0; i < 3; i++) begin
      step("t1", 0, 0, 1);
      check("t1_id", 32'(bus.alloc_id), 32'(NIN + i));
    end
    step("t1_idle", 0, 0, 0);

    // 2: recycled 5,3,7 then fresh 8
    do_reset();
    step("t2f", 1, 5, 0);
    step("t2f", 1, 3, 0);
    step("t2f", 1, 7, 0);
    step("t2a", 0, 0, 1); check("t2_id0", 32'(bus.alloc_id), 5);
    step("t2a", 0, 0, 1); check("t2_id1", 32'(bus.alloc_id), 3);
    step("t2a", 0, 0, 1); check("t2_id2", 32'(bus.alloc_id), 7);
    step("t2a", 0, 0, 1); check("t2_id3", 32'(bus.alloc_id), 8);
    check("t2_rec3", 32'(bus.alloc_recycled), 0);
    check("t2_empty", 32'(bus.empty), 1);

    // 3: overfill with head offset so the drain wraps
    step("t3pre", 1, 1, 0);
    step("t3pre", 0, 0, 1);
    for (int i = 0; i < 9; i++) step("t3f", 1, 20 + i, 0);
    check("t3_full", 32'(bus.full), 1);
    check("t3_ready", 32'(bus.free_ready), 0);
    for (int i = 0; i < 8; i++) begin
      step("t3a", 0, 0, 1);
      check("t3_id", 32'(bus.alloc_id), 32'(20 + i));
    end

    // 4: simultaneous push and pop on empty FIFO
    do_reset();
    step("t4", 1, 4, 1);
    check("t4_id", 32'(bus.alloc_id), 8);
    check("t4_cnt", 32'(bus.count), 1);
    step("t4b", 0, 0, 1);
    check("t4_rec", 32'(bus.alloc_id), 4);

    // 5: fresh counter exhaustion
    do_reset();
    guard = 0;
    while (m_fresh != 254 && guard < 400) begin
      step("t5run", 0, 0, 1);
      guard++;
    end
    check("t5_guard", 32'(guard < 400), 1);
    step("t5a", 0, 0, 1); check("t5_id254", 32'(bus.alloc_id), 254);
    step("t5b", 0, 0, 1); check("t5_err", 32'(bus.alloc_err), 1);
    check("t5_id255", 32'(bus.alloc_id), 255);
    step("t5c", 0, 0, 1);
    step("t5d", 1, 255, 0);

    // 6: duplicate free, then reset mid-burst
    do_reset();
    step("t6", 1, 6, 0);
    step("t6", 1, 6, 0);
`ifdef RECYCLE_DUP_CHECK_EN
    check("t6_cnt", 32'(bus.count), 1);
    check("t6_dup", 32'(bus.dup_drop), 1);
`else
    check("t6_cnt", 32'(bus.count), 2);
`endif
    step("t6c", 0, 0, 0);
    bus.alloc_req = 1'b1; bus.free_valid = 1'b1; bus.free_id = 8'd9;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    @(posedge clk); #1;
    check_all("t6_rst_hold");
    bus.alloc_req = 1'b0; bus.free_valid = 1'b0;
    rst = 1'b1;

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      step("rnd", $urandom_range(0, 1) == 1, (r == 0) ? INV : r, $urandom_range(0, 9) < 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
